// File: rtl/dram_cmd_arbiter.sv
// Arbitrates one MIG app/wdf port between a BL8 read requester and a two-beat BL8 write requester.
// Build option: define ARB_STARVE_GUARD_EN to force a pending write after MAX_RD_STREAK read grants.
module dram_cmd_arbiter #(
    parameter int ADDR_WIDTH     = 27,
    parameter int APP_DATA_WIDTH = 256,
    parameter int MAX_RD_STREAK  = 16
) (
    input  logic                        dram_clk,
    input  logic                        reset,
    input  logic                        rd_priority,
    input  logic                        rd_req,
    input  logic [ADDR_WIDTH-1:0]       rd_addr,
    output logic                        rd_ack,
    input  logic                        wr_req,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic [2*APP_DATA_WIDTH-1:0] wr_data,
    output logic                        wr_ack,
    input  logic                        app_rdy,
    output logic                        app_en,
    output logic [2:0]                  app_cmd,
    output logic [ADDR_WIDTH-1:0]       app_addr,
    input  logic                        app_wdf_rdy,
    output logic                        app_wdf_wren,
    output logic                        app_wdf_end,
    output logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
    output logic                        error,
    output logic [2:0]                  dbg_state
);
    // Handshakes: requests are level signals held until their 1-cycle ack; MIG command and
    // write-data beats transfer on an edge where the valid (app_en / app_wdf_wren) and the
    // matching ready (app_rdy / app_wdf_rdy) are both high.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_CMD = 3'd1,
        WR_CMD = 3'd2,
        WR_D1  = 3'd3,
        WR_D2  = 3'd4,
        ERROR  = 3'd5
    } state_t;

    localparam logic [2:0] CMD_RD = 3'b001;
    localparam logic [2:0] CMD_WR = 3'b000;

    state_t                      state;
    logic                        last_grant_wr;
    logic [2*APP_DATA_WIDTH-1:0] wr_buf;
    logic                        force_wr;
    logic                        pick_wr;
    logic                        grant;
    logic [ADDR_WIDTH-1:0]       pick_addr;

    assign dbg_state = state;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(MAX_RD_STREAK + 1);
    logic [SW-1:0] rd_streak;

    assign force_wr = (rd_streak == SW'(MAX_RD_STREAK));

    always_ff @(posedge dram_clk) begin
        if (reset) begin
            rd_streak <= '0;
        end else if (grant) begin
            if (pick_wr)
                rd_streak <= '0;
            else if (rd_streak != SW'(MAX_RD_STREAK))
                rd_streak <= rd_streak + SW'(1);
        end
    end
`else
    assign force_wr = 1'b0;
`endif

    // The ack cycle blocks new grants so a requester still holding its request is not served twice.
    assign grant     = (state == IDLE) && (rd_req || wr_req) && !rd_ack && !wr_ack;
    assign pick_addr = pick_wr ? wr_addr : rd_addr;

    always_comb begin
        pick_wr = wr_req;
        if (rd_req && wr_req)
            pick_wr = force_wr || (!rd_priority && !last_grant_wr);
    end

    always_ff @(posedge dram_clk) begin
        if (reset) begin
            state         <= IDLE;
            last_grant_wr <= 1'b1;
            wr_buf        <= '0;
            app_en        <= 1'b0;
            app_cmd       <= CMD_RD;
            app_addr      <= '0;
            app_wdf_wren  <= 1'b0;
            app_wdf_end   <= 1'b0;
            app_wdf_data  <= '0;
            rd_ack        <= 1'b0;
            wr_ack        <= 1'b0;
            error         <= 1'b0;
        end else begin
            rd_ack <= 1'b0;
            wr_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        last_grant_wr <= pick_wr;
                        if (pick_addr[2:0] != 3'b000) begin
                            error <= 1'b1;
                            state <= ERROR;
                        end else begin
                            app_en   <= 1'b1;
                            app_addr <= pick_addr;
                            app_cmd  <= pick_wr ? CMD_WR : CMD_RD;
                            if (pick_wr)
                                wr_buf <= wr_data;
                            state <= pick_wr ? WR_CMD : RD_CMD;
                        end
                    end
                end
                RD_CMD: begin
                    if (app_en && app_rdy) begin
                        app_en <= 1'b0;
                        rd_ack <= 1'b1;
                        state  <= IDLE;
                    end
                end
                WR_CMD: begin
                    if (app_en && app_rdy) begin
                        app_en       <= 1'b0;
                        app_wdf_wren <= 1'b1;
                        app_wdf_end  <= 1'b0;
                        app_wdf_data <= wr_buf[APP_DATA_WIDTH-1:0];
                        state        <= WR_D1;
                    end
                end
                WR_D1: begin
                    if (app_wdf_rdy) begin
                        app_wdf_data <= wr_buf[2*APP_DATA_WIDTH-1:APP_DATA_WIDTH];
                        app_wdf_end  <= 1'b1;
                        state        <= WR_D2;
                    end
                end
                WR_D2: begin
                    if (app_wdf_rdy) begin
                        app_wdf_wren <= 1'b0;
                        app_wdf_end  <= 1'b0;
                        wr_ack       <= 1'b1;
                        state        <= IDLE;
                    end
                end
                ERROR: begin
                    app_en       <= 1'b0;
                    app_wdf_wren <= 1'b0;
                    app_wdf_end  <= 1'b0;
                end
                default: state <= ERROR;
            endcase
        end
    end
endmodule

// File: tb/tb_dram_cmd_arbiter.sv
// Bench for dram_cmd_arbiter: directed vector table, multi-cycle corner sequences, then random traffic
// against a handshake-step model. Follows ARB_STARVE_GUARD_EN the same way the design does.
module tb_dram_cmd_arbiter;
    localparam int AW   = 27;
    localparam int DW   = 32;
    localparam int MAXS = 4;
    localparam int CW   = 3 + AW;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic            dram_clk = 1'b0;
    logic            reset, rd_priority, rd_req, wr_req, app_rdy, app_wdf_rdy;
    logic [AW-1:0]   rd_addr, wr_addr;
    logic [2*DW-1:0] wr_data;
    logic            rd_ack, wr_ack, app_en, app_wdf_wren, app_wdf_end, error;
    logic [2:0]      app_cmd, dbg_state;
    logic [AW-1:0]   app_addr;
    logic [DW-1:0]   app_wdf_data;

    int vectors     = 0;
    int miscompares = 0;

    dram_cmd_arbiter #(.ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .MAX_RD_STREAK(MAXS)) dut (
        .dram_clk(dram_clk), .reset(reset), .rd_priority(rd_priority),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .app_rdy(app_rdy), .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
        .app_wdf_rdy(app_wdf_rdy), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_data(app_wdf_data), .error(error), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 dram_clk = ~dram_clk;

    task automatic tick();
        @(posedge dram_clk);
        @(negedge dram_clk);
    endtask

    task automatic do_reset();
        @(negedge dram_clk);
        reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
        @(posedge dram_clk);
        @(posedge dram_clk);
        @(negedge dram_clk);
        reset = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // directed vector table
    typedef struct {
        logic            rd_req, wr_req, rd_priority;
        logic [AW-1:0]   rd_addr, wr_addr;
        logic [2*DW-1:0] wr_data;
        logic            exp_wr;
        logic [AW-1:0]   exp_addr;
        int              exp_ack_cyc;
    } vec_t;
    vec_t tbl[9];

    // reference model: queue of outstanding handshake steps of the granted transaction
    localparam int S_CMD = 0, S_B1 = 1, S_B2 = 2;
    int            step_q[$];
    logic [CW-1:0] exp_q[$];
    logic          m_rd_ack, m_wr_ack, m_err, m_last_wr, m_cur_wr;
    int            m_streak;
    logic [DW-1:0] m_beat1, m_beat2;

    function automatic void model_reset();
        step_q.delete(); exp_q.delete();
        m_rd_ack = 0; m_wr_ack = 0; m_err = 0; m_last_wr = 1; m_cur_wr = 0; m_streak = 0;
        m_beat1 = '0; m_beat2 = '0;
    endfunction

    function automatic void model_step();
        logic          ack_cycle, take_wr, rdy;
        logic [AW-1:0] a;
        ack_cycle = m_rd_ack | m_wr_ack;
        m_rd_ack = 0; m_wr_ack = 0;
        if (m_err) return;
        if (step_q.size() != 0) begin
            rdy = (step_q[0] == S_CMD) ? app_rdy : app_wdf_rdy;
            if (rdy) begin
                void'(step_q.pop_front());
                if (step_q.size() == 0) begin
                    if (m_cur_wr) m_wr_ack = 1; else m_rd_ack = 1;
                end
            end
        end else if (!ack_cycle && (rd_req || wr_req)) begin
            if (!rd_req) take_wr = 1;
            else if (!wr_req) take_wr = 0;
            else if (GUARD && m_streak >= MAXS) take_wr = 1;
            else if (rd_priority) take_wr = 0;
            else take_wr = !m_last_wr;
            a = take_wr ? wr_addr : rd_addr;
            m_last_wr = take_wr;
            m_streak  = take_wr ? 0 : ((m_streak < MAXS) ? m_streak + 1 : MAXS);
            if (a % 8 != 0) begin
                m_err = 1;
            end else begin
                m_cur_wr = take_wr;
                exp_q.push_back({take_wr ? 3'b000 : 3'b001, a});
                step_q.push_back(S_CMD);
                if (take_wr) begin
                    step_q.push_back(S_B1);
                    step_q.push_back(S_B2);
                    m_beat1 = wr_data[DW-1:0];
                    m_beat2 = wr_data[2*DW-1:DW];
                end
            end
        end
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] r;
        r = AW'($urandom);
        r[2:0] = 3'b000;
        return r;
    endfunction

    // driver: requesters hold until ack, then maybe re-issue; MIG readies random
    task automatic drive_random();
        if (rd_req) begin
            if (rd_ack) begin
                rd_req = 1'($urandom_range(0, 1));
                if (rd_req) rd_addr = rand_addr();
            end
        end else if ($urandom_range(0, 3) == 0) begin
            rd_req = 1'b1; rd_addr = rand_addr();
        end
        if (wr_req) begin
            if (wr_ack) begin
                wr_req = 1'($urandom_range(0, 1));
                if (wr_req) begin wr_addr = rand_addr(); wr_data = {$urandom, $urandom}; end
            end
        end else if ($urandom_range(0, 3) == 0) begin
            wr_req = 1'b1; wr_addr = rand_addr(); wr_data = {$urandom, $urandom};
        end
        if ($urandom_range(0, 19) == 0) rd_priority = ~rd_priority;
        app_rdy     = ($urandom_range(0, 3) != 0);
        app_wdf_rdy = ($urandom_range(0, 3) != 0);
    endtask

    task automatic collect_grants(input int n, output logic [7:0] order, output int cnt);
        order = '0; cnt = 0;
        for (int c = 0; c < 60 && cnt < n; c++) begin
            tick();
            if (app_en) begin
                order[cnt] = (app_cmd == 3'b000);
                cnt++;
            end
        end
    endtask

    initial begin
        int            en_cnt, en_cyc, ack_cyc, cnt, a_cnt, b_cnt, ack_cnt, wren_cnt, head;
        logic          ack_wr;
        logic [2:0]    got_cmd;
        logic [AW-1:0] got_addr;
        logic [DW-1:0] b1, b2;
        logic [7:0]    order;
        logic [CW-1:0] exp_cmd;

        reset = 1'b1; rd_priority = 0; rd_req = 0; wr_req = 0; app_rdy = 1; app_wdf_rdy = 1;
        rd_addr = '0; wr_addr = '0; wr_data = '0;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 27'h8,       27'h0,   64'h0,                   1'b0, 27'h8,       2};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 27'h0,       27'h20,  64'h2222_0002_1111_0001, 1'b1, 27'h20,      4};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 27'h40,      27'h38,  64'h0,                   1'b0, 27'h40,      2};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 27'h50,      27'h48,  64'hDEAD_BEEF_CAFE_F00D, 1'b1, 27'h48,      4};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 27'h58,      27'h60,  64'h0,                   1'b0, 27'h58,      2};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 27'h68,      27'h70,  64'h0,                   1'b0, 27'h68,      2};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 27'h78,      27'h80,  64'h0123_4567_89AB_CDEF, 1'b1, 27'h80,      4};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 27'h7FFFFF8, 27'h0,   64'h0,                   1'b0, 27'h7FFFFF8, 2};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 27'h0,       27'h0,   64'hFFFF_FFFF_0000_0000, 1'b1, 27'h0,       4};

        do_reset();
        check("rst_strobes", {app_en, app_wdf_wren, app_wdf_end, rd_ack, wr_ack, error}, 6'b0);
        check("rst_cmd", app_cmd, 3'b001);
        check("rst_addr", app_addr, 0);
        check("rst_wdf_data", app_wdf_data, 0);
        check("rst_state", dbg_state, 0);

        for (int i = 0; i < 9; i++) begin
            rd_req = tbl[i].rd_req; wr_req = tbl[i].wr_req; rd_priority = tbl[i].rd_priority;
            rd_addr = tbl[i].rd_addr; wr_addr = tbl[i].wr_addr; wr_data = tbl[i].wr_data;
            app_rdy = 1; app_wdf_rdy = 1;
            en_cnt = 0; en_cyc = -1; ack_cyc = -1; ack_wr = 0; got_cmd = 0; got_addr = 0; b1 = 0; b2 = 0;
            for (int c = 1; c <= 7; c++) begin
                tick();
                if (app_en) begin
                    en_cnt++;
                    if (en_cyc < 0) en_cyc = c;
                    got_cmd = app_cmd; got_addr = app_addr;
                end
                if (app_wdf_wren) begin
                    if (app_wdf_end) b2 = app_wdf_data; else b1 = app_wdf_data;
                end
                if ((rd_ack || wr_ack) && ack_cyc < 0) begin
                    ack_cyc = c; ack_wr = wr_ack; rd_req = 0; wr_req = 0;
                end
            end
            check($sformatf("v%0d_en_cycle", i), en_cyc, 1);
            check($sformatf("v%0d_en_count", i), en_cnt, 1);
            check($sformatf("v%0d_cmd", i), got_cmd, tbl[i].exp_wr ? 3'b000 : 3'b001);
            check($sformatf("v%0d_addr", i), got_addr, tbl[i].exp_addr);
            check($sformatf("v%0d_ack_cycle", i), ack_cyc, tbl[i].exp_ack_cyc);
            check($sformatf("v%0d_ack_side", i), ack_wr, tbl[i].exp_wr);
            if (tbl[i].exp_wr) begin
                check($sformatf("v%0d_beat1", i), b1, tbl[i].wr_data[DW-1:0]);
                check($sformatf("v%0d_beat2", i), b2, tbl[i].wr_data[2*DW-1:DW]);
            end
        end

        // write-data stall: beat 1 held while app_wdf_rdy is low
        do_reset();
        wr_req = 1; wr_addr = 27'h100; wr_data = {32'hBBBB_0002, 32'hAAAA_0001};
        app_rdy = 1; app_wdf_rdy = 0;
        a_cnt = 0; b_cnt = 0; ack_cnt = 0; ack_cyc = -1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (app_wdf_wren && !app_wdf_end && app_wdf_data == 32'hAAAA_0001) a_cnt++;
            if (app_wdf_wren && app_wdf_end && app_wdf_data == 32'hBBBB_0002) b_cnt++;
            if (wr_ack) begin ack_cnt++; ack_cyc = c; wr_req = 0; end
            app_wdf_rdy = (c >= 4);
        end
        check("stall_beat1_cycles", a_cnt, 3);
        check("stall_beat2_cycles", b_cnt, 1);
        check("stall_wr_ack_count", ack_cnt, 1);
        check("stall_wr_ack_cycle", ack_cyc, 6);

        // contention without priority alternates starting with the read
        do_reset();
        rd_req = 1; wr_req = 1; rd_priority = 0; rd_addr = 27'h200; wr_addr = 27'h300;
        app_rdy = 1; app_wdf_rdy = 1;
        collect_grants(4, order, cnt);
        check("alt_grant_count", cnt, 4);
        check("alt_order", order, 8'b0000_1010);

        // read priority: starvation guard forces the fifth grant to the write
        do_reset();
        rd_req = 1; wr_req = 1; rd_priority = 1;
        collect_grants(6, order, cnt);
        check("prio_grant_count", cnt, 6);
        check("prio_order", order, GUARD ? 8'b0001_0000 : 8'b0000_0000);

        // misaligned read address: sticky error, nothing else served
        do_reset();
        rd_req = 1; rd_addr = 27'h3; wr_req = 0;
        en_cnt = 0; ack_cnt = 0; wren_cnt = 0;
        tick();
        check("err_rise", error, 1'b1);
        rd_req = 0;
        tick();
        rd_req = 1; rd_addr = 27'h8; wr_req = 1; wr_addr = 27'h10;
        for (int c = 0; c < 10; c++) begin
            tick();
            en_cnt += int'(app_en); ack_cnt += int'(rd_ack) + int'(wr_ack); wren_cnt += int'(app_wdf_wren);
        end
        check("err_no_app_en", en_cnt, 0);
        check("err_no_ack", ack_cnt, 0);
        check("err_no_wren", wren_cnt, 0);
        check("err_sticky", error, 1'b1);
        do_reset();
        check("err_cleared_by_reset", error, 1'b0);

        // misaligned write address (only bit 2 set)
        wr_req = 1; wr_addr = 27'h104;
        tick();
        check("wr_err_rise", {error, app_en}, 2'b10);
        do_reset();

        // reset in the middle of a write data phase
        wr_req = 1; wr_addr = 27'h40; wr_data = {32'h2, 32'h1}; app_rdy = 1; app_wdf_rdy = 0;
        tick();
        tick();
        check("midrst_in_beat1", {app_wdf_wren, app_wdf_end}, 2'b10);
        reset = 1; wr_req = 0;
        tick();
        reset = 0;
        check("midrst_wren_low", {app_wdf_wren, app_en}, 2'b00);
        check("midrst_state_idle", dbg_state, 0);
        app_wdf_rdy = 1; ack_cnt = 0; wren_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            ack_cnt += int'(wr_ack); wren_cnt += int'(app_wdf_wren);
        end
        check("midrst_no_wr_ack", ack_cnt, 0);
        check("midrst_no_wren", wren_cnt, 0);

        // random traffic against the model
        do_reset();
        model_reset();
        rd_priority = 0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            @(posedge dram_clk);
            model_step();
            @(negedge dram_clk);
            head = (step_q.size() != 0) ? step_q[0] : -1;
            check("rnd_strobes", {app_en, app_wdf_wren, app_wdf_end, rd_ack, wr_ack, error},
                  {head == S_CMD, head == S_B1 || head == S_B2, head == S_B2, m_rd_ack, m_wr_ack, m_err});
            if (head == S_B1 || head == S_B2)
                check("rnd_wdf_data", app_wdf_data, (head == S_B1) ? m_beat1 : m_beat2);
            drive_random();
            if (app_en && app_rdy) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL rnd_cmd: got cmd %0h addr %0h, expected no command", app_cmd, app_addr);
                end else begin
                    exp_cmd = exp_q.pop_front();
                    check("rnd_cmd", {app_cmd, app_addr}, exp_cmd);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
